// File: rtl/onewire_slave.sv
// onewire_slave: device-side responder on an open-drain 1-wire bus.
// Answers a master reset with a presence pulse, receives a command byte
// through write slots (LSB first), then returns a response byte through
// read slots (LSB first). The line is only ever pulled low or released.
module onewire_slave #(
  parameter int CNT_W     = 16,
  parameter int RST_MIN   = 40000,
  parameter int PRES_WAIT = 1500,
  parameter int PRES_LEN  = 6000,
  parameter int SAMPLE    = 1500,
  parameter int HOLD      = 3000
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        port,
  input  logic [7:0] tx_data,
  output logic       dq_oe,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       tx_done,
  output logic       presence
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST_LOW = 3'd1,
    ST_PRES_WT = 3'd2,
    ST_PRES    = 3'd3,
    ST_RX      = 3'd4,
    ST_TX      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RST_MIN_C   = CNT_W'(RST_MIN);
  localparam logic [CNT_W-1:0] PRES_WT_END = CNT_W'(PRES_WAIT - 1);
  localparam logic [CNT_W-1:0] PRES_END    = CNT_W'(PRES_LEN - 1);
  localparam logic [CNT_W-1:0] SAMPLE_C    = CNT_W'(SAMPLE);
  localparam logic [CNT_W-1:0] HOLD_END    = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

  // Open-drain drive: pull low or release.
  assign port = dq_oe ? 1'b0 : 1'bz;

  logic             sync1_r;
  logic             dq_s;
  logic             dq_d_r;
  logic             oe_d1_r;
  logic             oe_d2_r;
  logic [CNT_W-1:0] low_cnt_r;

  state_t           state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt, cnt_inc_s;
  logic             active_r, active_nxt;
  logic [2:0]       idx_r, idx_nxt;
  logic [7:0]       sh_r, sh_nxt;
  logic [7:0]       rx_byte_nxt;
  logic             oe_nxt;
  logic             rx_valid_nxt, tx_done_nxt, pres_nxt;

  logic masked_s;
  logic fall_s;
  logic bus_rst_s;

  // Own drive plus two cycles of synchronizer tail after release is not a master edge.
  assign masked_s  = dq_oe | oe_d1_r | oe_d2_r;
  assign fall_s    = dq_d_r & ~dq_s & ~masked_s;
  assign bus_rst_s = (low_cnt_r == RST_MIN_C);
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Line synchronizer, edge history, drive history and master low-time counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r   <= 1'b1;
      dq_s      <= 1'b1;
      dq_d_r    <= 1'b1;
      oe_d1_r   <= 1'b0;
      oe_d2_r   <= 1'b0;
      low_cnt_r <= CNT_ZERO;
    end else begin
      sync1_r <= port;
      dq_s    <= sync1_r;
      dq_d_r  <= dq_s;
      oe_d1_r <= dq_oe;
      oe_d2_r <= oe_d1_r;
      if (dq_s || masked_s) begin
        low_cnt_r <= CNT_ZERO;
      end else if (low_cnt_r != RST_MIN_C) begin
        low_cnt_r <= low_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        low_cnt_r <= low_cnt_r;
      end
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      active_r <= 1'b0;
      idx_r    <= 3'd0;
      sh_r     <= 8'h00;
      rx_byte  <= 8'h00;
      dq_oe    <= 1'b0;
      rx_valid <= 1'b0;
      tx_done  <= 1'b0;
      presence <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      cnt_r    <= cnt_nxt;
      active_r <= active_nxt;
      idx_r    <= idx_nxt;
      sh_r     <= sh_nxt;
      rx_byte  <= rx_byte_nxt;
      dq_oe    <= oe_nxt;
      rx_valid <= rx_valid_nxt;
      tx_done  <= tx_done_nxt;
      presence <= pres_nxt;
    end
  end

  // Next-state and next-datapath logic; a qualified bus reset overrides everything.
  always_comb begin
    state_nxt    = state_r;
    cnt_nxt      = cnt_inc_s;
    active_nxt   = active_r;
    idx_nxt      = idx_r;
    sh_nxt       = sh_r;
    rx_byte_nxt  = rx_byte;
    oe_nxt       = dq_oe;
    rx_valid_nxt = 1'b0;
    tx_done_nxt  = 1'b0;
    pres_nxt     = 1'b0;

    if (bus_rst_s && (state_r != ST_RST_LOW)) begin
      state_nxt  = ST_RST_LOW;
      cnt_nxt    = CNT_ZERO;
      active_nxt = 1'b0;
      idx_nxt    = 3'd0;
      sh_nxt     = 8'h00;
      oe_nxt     = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          oe_nxt = 1'b0;
        end
        ST_RST_LOW: begin
          oe_nxt = 1'b0;
          if (dq_s) begin
            state_nxt = ST_PRES_WT;
            cnt_nxt   = CNT_ZERO;
          end else begin
            state_nxt = ST_RST_LOW;
          end
        end
        ST_PRES_WT: begin
          if (cnt_r == PRES_WT_END) begin
            state_nxt = ST_PRES;
            cnt_nxt   = CNT_ZERO;
            oe_nxt    = 1'b1;
          end else begin
            oe_nxt = 1'b0;
          end
        end
        ST_PRES: begin
          if (cnt_r == PRES_END) begin
            state_nxt  = ST_RX;
            cnt_nxt    = CNT_ZERO;
            oe_nxt     = 1'b0;
            pres_nxt   = 1'b1;
            idx_nxt    = 3'd0;
            active_nxt = 1'b0;
          end else begin
            oe_nxt = 1'b1;
          end
        end
        ST_RX: begin
          if (active_r) begin
            if (cnt_r == SAMPLE_C) begin
              sh_nxt     = {dq_s, sh_r[7:1]};
              idx_nxt    = idx_r + 3'd1;
              active_nxt = 1'b0;
              if (idx_r == 3'd7) begin
                rx_byte_nxt  = {dq_s, sh_r[7:1]};
                rx_valid_nxt = 1'b1;
                sh_nxt       = tx_data;
                idx_nxt      = 3'd0;
                state_nxt    = ST_TX;
                cnt_nxt      = CNT_ZERO;
              end else begin
                state_nxt = ST_RX;
              end
            end else begin
              active_nxt = 1'b1;
            end
          end else if (fall_s) begin
            active_nxt = 1'b1;
            cnt_nxt    = CNT_ZERO;
          end else begin
            active_nxt = 1'b0;
          end
        end
        ST_TX: begin
          if (active_r) begin
            if (cnt_r == HOLD_END) begin
              oe_nxt     = 1'b0;
              sh_nxt     = {1'b0, sh_r[7:1]};
              idx_nxt    = idx_r + 3'd1;
              active_nxt = 1'b0;
              if (idx_r == 3'd7) begin
                tx_done_nxt = 1'b1;
                idx_nxt     = 3'd0;
                state_nxt   = ST_RX;
                cnt_nxt     = CNT_ZERO;
              end else begin
                state_nxt = ST_TX;
              end
            end else begin
              active_nxt = 1'b1;
            end
          end else if (fall_s) begin
            active_nxt = 1'b1;
            cnt_nxt    = CNT_ZERO;
            oe_nxt     = ~sh_r[0];
          end else begin
            oe_nxt = 1'b0;
          end
        end
        default: begin
          state_nxt  = ST_IDLE;
          cnt_nxt    = CNT_ZERO;
          active_nxt = 1'b0;
          idx_nxt    = 3'd0;
          oe_nxt     = 1'b0;
        end
      endcase
    end
  end

endmodule
